// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cla_pkg
// Purpose : Shared types and constants for the serial carry-lookahead adder.
//           - state_t  : controller state encoding (IDLE / RUN / DONE)
//           - NIBBLE_W : width of the lookahead slice
//           - nib_count: number of slice passes needed for a given width
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// ============================================================================
// Module  : cla4_slice
// Purpose : Combinational 4-bit carry-lookahead adder slice. All carries are
//           formed directly from generate/propagate terms, so there is no
//           ripple path inside the slice.
// Ports   : x[3:0], y[3:0] - addends
//           cin            - carry into bit 0
//           sum[3:0]       - x + y + cin (low 4 bits)
//           cout           - carry out of bit 3
//           c3             - carry into bit 3 (signed-overflow detection)
// Revision: 1.0 - initial release
// ============================================================================
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];
  assign c3   = w_c[3];

endmodule : cla4_slice
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : cla_serial_adder
// Purpose : WIDTH-bit adder that reuses one 4-bit CLA slice for WIDTH/4
//           cycles, LSB nibble first. Operands enter and the result leaves
//           through valid/ready handshakes. {cout,sum} = a + b + cin.
// Ports   : clk, rst (sync, active-high)
//           in_valid / in_ready   - operand handshake (in_ready only in IDLE)
//           a, b [WIDTH-1:0], cin - operands
//           out_valid / out_ready - result handshake (out_valid only in DONE)
//           sum [WIDTH-1:0], cout - registered result
//           busy                  - high in RUN or DONE
//           ovf                   - signed overflow (only with CLA_SERIAL_OVF_EN)
// Options : define CLA_SERIAL_OVF_EN to add the ovf output.
// Revision: 1.0 - initial release
// ============================================================================
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;
`ifdef CLA_SERIAL_OVF_EN
  logic             w_slice_c3;
  logic             r_ovf;
`else
  logic             w_unused_c3;
`endif

  // The only carry path between nibbles is r_carry.
  cla4_slice u_slice (
    .x    (r_a_sh[3:0]),
    .y    (r_b_sh[3:0]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout),
`ifdef CLA_SERIAL_OVF_EN
    .c3   (w_slice_c3)
`else
    .c3   (w_unused_c3)
`endif
  );

  assign w_last = (r_idx == LAST_IDX);

  // Next-state and handshake decodes.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Drop the slice result into the nibble selected by r_idx.
  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < NIB; i++) begin
      if (r_idx == IDX_W'(i)) w_sum_next[i*NIBBLE_W +: NIBBLE_W] = w_slice_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          r_a_sh  <= r_a_sh >> NIBBLE_W;
          r_b_sh  <= r_b_sh >> NIBBLE_W;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_cout <= w_slice_cout;
`ifdef CLA_SERIAL_OVF_EN
            // Overflow = carry into MSB xor carry out of MSB (top nibble).
            r_ovf  <= w_slice_c3 ^ w_slice_cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef CLA_SERIAL_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule : cla_serial_adder
`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cla_serial_adder
// Purpose : Self-checking bench for cla_serial_adder. Three instances
//           (WIDTH = 16, 4, 32) share clock, reset and operand buses; each
//           has its own in_valid/out_ready. Directed vectors on the 16-bit
//           instance, then random transactions on the 4- and 32-bit ones.
// Options : CLA_SERIAL_OVF_EN enables the ovf checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cla_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] t_a;
  logic [31:0] t_b;
  logic        t_cin;
  logic [2:0]  t_iv;
  logic [2:0]  t_or;

  logic [2:0]  w_ir, w_ov, w_bz, w_co;
  logic [15:0] w_s16;
  logic [3:0]  w_s4;
  logic [31:0] w_s32;
`ifdef CLA_SERIAL_OVF_EN
  logic [2:0]  w_ovf;
`endif

  always #5 clk = ~clk;

  cla_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(t_iv[0]), .in_ready(w_ir[0]),
    .a(t_a[15:0]), .b(t_b[15:0]), .cin(t_cin), .out_valid(w_ov[0]),
    .out_ready(t_or[0]), .sum(w_s16), .cout(w_co[0]), .busy(w_bz[0])
`ifdef CLA_SERIAL_OVF_EN
    , .ovf(w_ovf[0])
`endif
  );

  cla_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(t_iv[1]), .in_ready(w_ir[1]),
    .a(t_a[3:0]), .b(t_b[3:0]), .cin(t_cin), .out_valid(w_ov[1]),
    .out_ready(t_or[1]), .sum(w_s4), .cout(w_co[1]), .busy(w_bz[1])
`ifdef CLA_SERIAL_OVF_EN
    , .ovf(w_ovf[1])
`endif
  );

  cla_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(t_iv[2]), .in_ready(w_ir[2]),
    .a(t_a), .b(t_b), .cin(t_cin), .out_valid(w_ov[2]),
    .out_ready(t_or[2]), .sum(w_s32), .cout(w_co[2]), .busy(w_bz[2])
`ifdef CLA_SERIAL_OVF_EN
    , .ovf(w_ovf[2])
`endif
  );

  // Observation mux for the instance under test.
  int          sel = 0;
  logic [31:0] o_sum;
  logic        o_cout, o_ir, o_ov, o_bz, o_ovf;

  always_comb begin
    o_sum  = 32'd0;
    o_cout = w_co[sel];
    o_ir   = w_ir[sel];
    o_ov   = w_ov[sel];
    o_bz   = w_bz[sel];
`ifdef CLA_SERIAL_OVF_EN
    o_ovf  = w_ovf[sel];
`else
    o_ovf  = 1'b0;
`endif
    case (sel)
      0:       o_sum = {16'd0, w_s16};
      1:       o_sum = {28'd0, w_s4};
      default: o_sum = w_s32;
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic start(input int s, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic early);
    sel = s;
    #1;
    check("in_ready_before_accept", {63'd0, o_ir}, 64'd1);
    t_a      = a;
    t_b      = b;
    t_cin    = c;
    t_iv[s]  = 1'b1;
    t_or[s]  = early;
    @(posedge clk);
    #1;
    t_iv[s]  = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (o_ov === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_tx();
    t_or[sel] = 1'b1;
    @(posedge clk);
    #1;
    t_or[sel] = 1'b0;
  endtask

  function automatic logic [32:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [63:0] m;
    logic [63:0] f;
    m = (64'd1 << w) - 64'd1;
    f = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c};
    return {f[w], f[31:0] & m[31:0]};
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] ra, rb;
    logic        rc, early;
    int          stall, w;
    logic [32:0] exp_res;

    rst   = 1'b1;
    t_a   = '0;
    t_b   = '0;
    t_cin = 1'b0;
    t_iv  = '0;
    t_or  = '0;
    sel   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, o_ir},   64'd1);
    check("rst_out_valid", {63'd0, o_ov},   64'd0);
    check("rst_busy",      {63'd0, o_bz},   64'd0);
    check("rst_sum",       {32'd0, o_sum},  64'd0);
    check("rst_cout",      {63'd0, o_cout}, 64'd0);
    rst = 1'b0;

    // Reset in the middle of RUN, with in_valid held high during reset.
    start(0, 32'h1234, 32'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("midrun_busy", {63'd0, o_bz}, 64'd1);
    rst     = 1'b1;
    t_iv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_rst_in_ready",  {63'd0, o_ir},   64'd1);
    check("midrun_rst_out_valid", {63'd0, o_ov},   64'd0);
    check("midrun_rst_busy",      {63'd0, o_bz},   64'd0);
    check("midrun_rst_sum",       {32'd0, o_sum},  64'd0);
    check("midrun_rst_cout",      {63'd0, o_cout}, 64'd0);
    rst     = 1'b0;
    t_iv[0] = 1'b0;

    start(0, 32'h1234, 32'h1111, 1'b0, 1'b0);
    wait_done(lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b0, 32'h2345});
    finish_tx();

    // Full carry ripple across every nibble.
    start(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    wait_done(lat);
    check("ripple_latency", 64'(lat), 64'd4);
    check("ripple_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b1, 32'h0000});
    finish_tx();

    // Carry-in participates.
    start(0, 32'h1234, 32'h4321, 1'b1, 1'b0);
    wait_done(lat);
    check("cin_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b0, 32'h5556});
    finish_tx();

    // Back-pressure: result held, new operands ignored while busy.
    start(0, 32'hA5A5, 32'h5A5A, 1'b0, 1'b0);
    wait_done(lat);
    check("bp_latency", 64'(lat), 64'd4);
    t_a     = 32'h0000;
    t_b     = 32'h0000;
    t_iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", {63'd0, o_ov},  64'd1);
      check("bp_sum",       {32'd0, o_sum}, 64'h0000_FFFF);
      check("bp_in_ready",  {63'd0, o_ir},  64'd0);
      @(posedge clk);
      #1;
    end
    t_iv[0] = 1'b0;
    finish_tx();
    check("bp_release_in_ready",  {63'd0, o_ir}, 64'd1);
    check("bp_release_out_valid", {63'd0, o_ov}, 64'd0);
    @(posedge clk);
    #1;
    check("bp_no_late_capture", {63'd0, o_bz}, 64'd0);

    // out_ready already high when DONE is entered.
    start(0, 32'h0F0F, 32'h0101, 1'b0, 1'b1);
    wait_done(lat);
    check("early_ready_latency", 64'(lat), 64'd4);
    check("early_ready_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b0, 32'h1010});
    @(posedge clk);
    #1;
    t_or[0] = 1'b0;
    check("early_ready_idle", {63'd0, o_ir}, 64'd1);

    // Signed overflow cases.
    start(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    wait_done(lat);
    check("ovf_pos_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b0, 32'h8000});
`ifdef CLA_SERIAL_OVF_EN
    check("ovf_pos_flag", {63'd0, o_ovf}, 64'd1);
`endif
    finish_tx();
    start(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    wait_done(lat);
    check("ovf_neg_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b1, 32'h0000});
`ifdef CLA_SERIAL_OVF_EN
    check("ovf_neg_flag", {63'd0, o_ovf}, 64'd0);
`endif
    finish_tx();

    // Width 4: single RUN cycle.
    start(1, 32'hF, 32'h0, 1'b1, 1'b0);
    wait_done(lat);
    check("w4_latency", 64'(lat), 64'd1);
    check("w4_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b1, 32'h0});
    finish_tx();

    // Width 32: eight RUN cycles.
    start(2, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    wait_done(lat);
    check("w32_latency", 64'(lat), 64'd8);
    check("w32_result", {31'd0, o_cout, o_sum}, {31'd0, 1'b1, 32'h0});
    finish_tx();

    // Random transactions on the 4- and 32-bit instances.
    for (int i = 0; i < 1000; i++) begin
      for (int s = 1; s <= 2; s++) begin
        w       = (s == 1) ? 4 : 32;
        ra      = $urandom;
        rb      = $urandom;
        rc      = 1'($urandom_range(0, 1));
        early   = ($urandom_range(0, 3) == 0);
        stall   = early ? 0 : int'($urandom_range(0, 3));
        exp_res = ref_add(w, ra, rb, rc);
        start(s, ra, rb, rc, early);
        wait_done(lat);
        check("rand_latency", 64'(lat), 64'(w / 4));
        repeat (stall) @(posedge clk);
        if (stall > 0) #1;
        check("rand_result", {31'd0, o_cout, o_sum}, {31'd0, exp_res});
        if (early) begin
          @(posedge clk);
          #1;
          t_or[s] = 1'b0;
        end else begin
          finish_tx();
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_cla_serial_adder
`default_nettype wire
